// File: rtl/pico_native_mem_responder.sv
// pico_native_mem_responder: picorv32 native-bus memory responder with programmable wait states
// Ports: clk/rst (sync, active-high); mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb request in;
// mem_ready/mem_rdata response out; err flags out-of-window access; busy spans capture..ready;
// fetch_cnt counts completed instruction fetches. FETCH_INIT is the reset value of fetch_cnt.
module pico_native_mem_responder #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WAIT_CYC   = 1,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
  parameter logic [15:0] FETCH_INIT = 16'h0000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err,
  output logic        busy,
  output logic [15:0] fetch_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYC);
  state_t r_state, w_next;
  logic [31:0] r_ram [2**ADDR_W];
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [31:0] r_wdata, r_rdata, w_off;
  logic [3:0] r_wstrb, r_cnt;
  logic [15:0] r_fetch;
  logic r_instr, r_inwin, w_inwin, w_rd;
  assign w_off = mem_addr - BASE_ADDR;
  // addresses below BASE_ADDR wrap to large offsets and fall outside the window
  assign w_inwin = {32'd0, w_off} < (64'd4 << ADDR_W);
  assign w_idx = w_off[ADDR_W+1:2];
  always_comb begin
    w_next = r_state == IDLE ? (mem_valid ? (WC == 4'd0 ? RESP : WAIT) : IDLE)
           : r_state == WAIT ? (!mem_valid ? IDLE : r_cnt == 4'd1 ? RESP : WAIT)
           : IDLE;
    mem_ready = r_state == RESP;
    err = mem_ready & ~r_inwin;
    busy = r_state != IDLE;
    // RAM is read on the edge entering RESP so data is registered for the whole RESP cycle
    w_rd = w_next == RESP && r_state != RESP;
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rdata <= '0;
      r_fetch <= FETCH_INIT;
    end else begin
      if (r_state == IDLE && mem_valid) begin
        r_idx <= w_idx;
        r_inwin <= w_inwin;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
        r_instr <= mem_instr;
        r_cnt <= WC;
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_rd)
        r_rdata <= r_state == IDLE ? (w_inwin ? r_ram[w_idx] : ERR_DATA)
                                   : (r_inwin ? r_ram[r_idx] : ERR_DATA);
      if (r_state == RESP && r_instr) r_fetch <= r_fetch + 16'd1;
    end
  end
  always_ff @(posedge clk)
    if (!rst && r_state == RESP && r_inwin)
      for (int i = 0; i < 4; i++)
        if (r_wstrb[i]) r_ram[r_idx][8*i+:8] <= r_wdata[8*i+:8];
  assign mem_rdata = r_rdata;
  assign fetch_cnt = r_fetch;
endmodule

// File: tb/tb_pico_native_mem_responder.sv
// tb_pico_native_mem_responder: directed tests against a transaction-level memory model
module tb_pico_native_mem_responder;
  logic clk = 0, rst = 1, valid = 0, instr = 0, sel = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] wstrb = 0;
  logic ra, rb, ea, eb, ba, bb;
  logic [31:0] da, db;
  logic [15:0] fa, fb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pico_native_mem_responder #(.WAIT_CYC(1)) u_a (
    .clk(clk), .rst(rst), .mem_valid(valid & !sel), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ra), .mem_rdata(da), .err(ea),
    .busy(ba), .fetch_cnt(fa));
  pico_native_mem_responder #(.WAIT_CYC(0), .FETCH_INIT(16'hFFFF)) u_b (
    .clk(clk), .rst(rst), .mem_valid(valid & sel), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rb), .mem_rdata(db), .err(eb),
    .busy(bb), .fetch_cnt(fb));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  int n = 0, due = 0, last_rdy = 0, gap = 0, mkey = 0;
  bit pend = 0, ms = 0, mwin = 0, mins = 0;
  logic [31:0] mexp = 0, mwd = 0, moff, mtmp;
  logic [3:0] mws = 0;
  logic [15:0] mf [2];
  logic [31:0] mm [int];
  // a request taken at edge c answers after edge c+WAIT_CYC and retires on the following edge
  always @(posedge clk) begin
    n++;
    if (rst) begin
      pend = 0;
      mf[0] = 16'h0000;
      mf[1] = 16'hFFFF;
    end else if (pend && n == due + 1) begin
      if (mwin && mws != 0) begin
        mtmp = mm.exists(mkey) ? mm[mkey] : 'x;
        for (int i = 0; i < 4; i++) if (mws[i]) mtmp[8*i+:8] = mwd[8*i+:8];
        mm[mkey] = mtmp;
      end
      if (mins) mf[ms] = mf[ms] + 16'd1;
      pend = 0;
    end else if (!pend && valid) begin
      ms = sel;
      moff = addr - 32'h0;
      mwin = moff < 32'd4096;
      mkey = int'(ms) * 1024 + int'(moff[11:2]);
      mexp = !mwin ? 32'hDEAD_BEEF : mm.exists(mkey) ? mm[mkey] : 'x;
      mws = wstrb;
      mwd = wdata;
      mins = instr;
      pend = 1;
      due = n + (ms ? 0 : 1);
    end
  end
  always @(negedge clk) begin
    bit er;
    if (n > 0) begin
      er = pend && n == due;
      chk("ready_a", {31'd0, ra}, {31'd0, er && !ms});
      chk("ready_b", {31'd0, rb}, {31'd0, er && ms});
      chk("busy_a", {31'd0, ba}, {31'd0, pend && !ms});
      chk("busy_b", {31'd0, bb}, {31'd0, pend && ms});
      if (er) begin
        chk("err", {31'd0, ms ? eb : ea}, {31'd0, !mwin});
        if (!$isunknown(mexp)) chk("rdata", ms ? db : da, mexp);
      end
      chk("fetch_a", {16'd0, fa}, {16'd0, mf[0]});
      chk("fetch_b", {16'd0, fb}, {16'd0, mf[1]});
      if (ra | rb) begin
        gap = n - last_rdy;
        last_rdy = n;
      end
    end
  end
  logic [31:0] rd;
  bit e;
  int lat;
  task automatic xfer(input bit s, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input bit ins, input bit hold, output logic [31:0] d, output bit er, output int l);
    sel = s; addr = a; wdata = wd; wstrb = ws; instr = ins; valid = 1; l = 0;
    do begin
      @(posedge clk); l++;
      @(negedge clk);
    end while (!(s ? rb : ra) && l < 20);
    if (!(s ? rb : ra)) begin
      total++; bad++;
      $display("FAIL timeout: no ready after %0d cycles for addr %h", l, a);
    end
    d = s ? db : da;
    er = s ? eb : ea;
    @(posedge clk); #1 valid = hold;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ra}, 0);
    chk("rst_busy", {31'd0, ba}, 0);
    chk("rst_err", {31'd0, ea}, 0);
    chk("rst_rdata", da, 0);
    chk("rst_fetch_b", {16'd0, fb}, 32'h0000FFFF);
    @(posedge clk); #1;
    xfer(0, 32'h10, 32'h1234_5678, 4'hF, 0, 0, rd, e, lat);
    chk("t1_wlat", lat, 2);
    chk("t1_werr", {31'd0, e}, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, e, lat);
    chk("t1_rlat", lat, 2);
    chk("t1_rdata", rd, 32'h1234_5678);
    chk("t1_rerr", {31'd0, e}, 0);
    xfer(0, 32'h20, 32'hAABB_CCDD, 4'hF, 0, 0, rd, e, lat);
    xfer(0, 32'h20, 32'h1122_3344, 4'b0101, 0, 0, rd, e, lat);
    chk("t2_old", rd, 32'hAABB_CCDD);
    xfer(0, 32'h20, 32'h0, 4'h0, 0, 0, rd, e, lat);
    chk("t2_rdata", rd, 32'hAA22_CC44);
    xfer(0, 32'h0, 32'hCAFE_0000, 4'hF, 0, 0, rd, e, lat);
    xfer(0, 32'h1000, 32'h0, 4'h0, 0, 0, rd, e, lat);
    chk("t3_rdata", rd, 32'hDEAD_BEEF);
    chk("t3_rerr", {31'd0, e}, 1);
    xfer(0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 0, rd, e, lat);
    chk("t3_werr", {31'd0, e}, 1);
    xfer(0, 32'h0, 32'h0, 4'h0, 0, 0, rd, e, lat);
    chk("t3_word0", rd, 32'hCAFE_0000);
    xfer(1, 32'h40, 32'h4040_4040, 4'hF, 0, 0, rd, e, lat);
    xfer(1, 32'h44, 32'h4444_4444, 4'hF, 0, 0, rd, e, lat);
    xfer(1, 32'h40, 32'h0, 4'h0, 0, 1, rd, e, lat);
    chk("t4_lat0", lat, 1);
    chk("t4_rd0", rd, 32'h4040_4040);
    xfer(1, 32'h44, 32'h0, 4'h0, 0, 1, rd, e, lat);
    chk("t4_gap1", gap, 2);
    chk("t4_rd1", rd, 32'h4444_4444);
    xfer(1, 32'h40, 32'h0, 4'h0, 0, 0, rd, e, lat);
    chk("t4_gap2", gap, 2);
    chk("t4_rd2", rd, 32'h4040_4040);
    xfer(0, 32'h8, 32'h0808_0808, 4'hF, 0, 0, rd, e, lat);
    sel = 0; addr = 32'h8; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; instr = 1; valid = 1;
    @(posedge clk); #1 rst = 1; valid = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t5_ready", {31'd0, ra}, 0);
    chk("t5_busy", {31'd0, ba}, 0);
    chk("t5_err", {31'd0, ea}, 0);
    chk("t5_rdata", da, 0);
    chk("t5_fetch", {16'd0, fa}, 0);
    @(posedge clk); #1;
    xfer(0, 32'h8, 32'h0, 4'h0, 0, 0, rd, e, lat);
    chk("t5_word8", rd, 32'h0808_0808);
    for (int i = 0; i < 5; i++) xfer(0, 32'h10, 32'h0, 4'h0, i < 3, 0, rd, e, lat);
    chk("t6_fetch3", {16'd0, fa}, 3);
    xfer(1, 32'h44, 32'h0, 4'h0, 1, 0, rd, e, lat);
    chk("t6_wrap", {16'd0, fb}, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
